// File: rtl/air_hockey_pkg.sv
// air_hockey_pkg: shared state encoding, winner codes, score width and field geometry
package air_hockey_pkg;
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, GOAL = 3'd3, OVER = 3'd4} phase_t;
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1 = 2'b01;
   localparam logic [1:0] WIN_P2 = 2'b10;
   localparam int SCORE_W = 4;
   localparam int DEF_FIELD_X_MIN = 0;
   localparam int DEF_FIELD_X_MAX = 1023;
   localparam int DEF_GOAL_Y_MIN = 284;
   localparam int DEF_GOAL_Y_MAX = 484;
   localparam int DEF_BALL_RADIUS = 10;
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return &s ? s : s + 1'b1;
   endfunction
endpackage

// File: rtl/game_ctl_if.sv
// game_ctl_if: puck datapath and overlay bundle of the match sequencer
//   ball_xpos/ball_ypos : puck centre from draw_ball_ctl
//   ball_hold/ball_reset: puck freeze level and re-centre pulse
//   score_p1/score_p2, phase, goal_flash, winner: match status for the overlays
interface game_ctl_if;
   import air_hockey_pkg::*;
   logic [11:0] ball_xpos;
   logic [11:0] ball_ypos;
   logic ball_hold;
   logic ball_reset;
   logic [SCORE_W-1:0] score_p1;
   logic [SCORE_W-1:0] score_p2;
   logic [2:0] phase;
   logic goal_flash;
   logic [1:0] winner;
   modport master (input ball_xpos, ball_ypos, output ball_hold, ball_reset, score_p1, score_p2, phase, goal_flash, winner);
   modport slave (output ball_xpos, ball_ypos, input ball_hold, ball_reset, score_p1, score_p2, phase, goal_flash, winner);
endinterface

// File: rtl/edge_detect.sv
// edge_detect: registered one-cycle pulse on a rising edge of d
//   clk, rst: clock and async active-high reset
//   d: level input, p: pulse high in the cycle after the edge that samples d rising
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic p
);
   logic q, armed;
   // armed stays low for the first cycle out of reset so a level already high is not a rise
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         q <= 1'b0;
         armed <= 1'b0;
         p <= 1'b0;
      end else begin
         q <= d;
         armed <= 1'b1;
         p <= armed & d & ~q;
      end
endmodule

// File: rtl/game_ctl.sv
// game_ctl: air hockey match sequencer (serve, play, goal detection, scoring)
//   clk, rst : pixel clock, async active-high reset
//   vsync_in : frame tick on its rising edge
//   start    : start request, rising edge is the start event
//   bus      : puck position in, hold/reset/score/phase/flash/winner out
module game_ctl
   import air_hockey_pkg::*;
#(
   parameter int FIELD_X_MIN = DEF_FIELD_X_MIN,
   parameter int FIELD_X_MAX = DEF_FIELD_X_MAX,
   parameter int GOAL_Y_MIN = DEF_GOAL_Y_MIN,
   parameter int GOAL_Y_MAX = DEF_GOAL_Y_MAX,
   parameter int BALL_RADIUS = DEF_BALL_RADIUS,
   parameter int SERVE_FRAMES = 120,
   parameter int GOAL_FRAMES = 90,
   parameter int WIN_SCORE = 7
) (
   input logic clk,
   input logic rst,
   input logic vsync_in,
   input logic start,
   game_ctl_if.master bus
);
   phase_t state;
   logic tick, start_p, mouth, gl, gr, won;
   logic [7:0] cnt;
   logic [12:0] x13, y13;
   logic [SCORE_W-1:0] s1, s2, n1, n2;
   logic [1:0] win;
   logic hold, rstp, flash;
   edge_detect u_vs (.clk(clk), .rst(rst), .d(vsync_in), .p(tick));
   edge_detect u_st (.clk(clk), .rst(rst), .d(start), .p(start_p));
   assign x13 = {1'b0, bus.ball_xpos};
   assign y13 = {1'b0, bus.ball_ypos};
   assign mouth = y13 >= 13'(GOAL_Y_MIN) && y13 <= 13'(GOAL_Y_MAX);
   assign gl = mouth && x13 <= 13'(FIELD_X_MIN + BALL_RADIUS);
   assign gr = mouth && x13 + 13'(BALL_RADIUS) >= 13'(FIELD_X_MAX);
   assign n1 = sat_inc(s1);
   assign n2 = sat_inc(s2);
   // left goal takes priority when both conditions hold
   assign won = gl ? n2 == SCORE_W'(WIN_SCORE) : n1 == SCORE_W'(WIN_SCORE);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         s1 <= '0;
         s2 <= '0;
         win <= WIN_NONE;
         hold <= 1'b1;
         rstp <= 1'b0;
         flash <= 1'b0;
      end else begin
         rstp <= 1'b0;
         case (state)
            IDLE, OVER: if (start_p) begin
               state <= SERVE;
               cnt <= '0;
               s1 <= '0;
               s2 <= '0;
               win <= WIN_NONE;
               hold <= 1'b1;
               rstp <= 1'b1;
            end
            SERVE: if (tick) begin
               if (cnt == 8'(SERVE_FRAMES - 1)) begin
                  state <= PLAY;
                  cnt <= '0;
                  hold <= 1'b0;
               end else cnt <= cnt + 8'd1;
            end
            PLAY: if (tick && (gl || gr)) begin
               cnt <= '0;
               hold <= 1'b1;
               if (gl) s2 <= n2;
               else s1 <= n1;
               if (won) begin
                  state <= OVER;
                  win <= gl ? WIN_P2 : WIN_P1;
               end else begin
                  state <= GOAL;
                  flash <= 1'b1;
               end
            end
            GOAL: if (tick) begin
               if (cnt == 8'(GOAL_FRAMES - 1)) begin
                  state <= SERVE;
                  cnt <= '0;
                  flash <= 1'b0;
                  rstp <= 1'b1;
               end else cnt <= cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   assign bus.phase = state;
   assign bus.score_p1 = s1;
   assign bus.score_p2 = s2;
   assign bus.winner = win;
   assign bus.ball_hold = hold;
   assign bus.ball_reset = rstp;
   assign bus.goal_flash = flash;
endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: directed plus randomized check of game_ctl against a frame-level match model
module tb_game_ctl;
   localparam int XMIN = 0, XMAX = 1023, YMIN = 284, YMAX = 484, R = 10;
   localparam int SF = 120, GF = 90, WIN = 7;
   logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, start = 1'b0;
   int checks = 0, errors = 0;
   int m_phase, m_cnt, m_s1, m_s2, m_win;
   game_ctl_if bus ();
   game_ctl dut (.clk(clk), .rst(rst), .vsync_in(vsync), .start(start), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".phase"}, 32'(bus.phase), 32'(m_phase));
      chk({tag, ".p1"}, 32'(bus.score_p1), 32'(m_s1));
      chk({tag, ".p2"}, 32'(bus.score_p2), 32'(m_s2));
      chk({tag, ".winner"}, 32'(bus.winner), 32'(m_win));
      chk({tag, ".hold"}, 32'(bus.ball_hold), 32'(m_phase != 2));
      chk({tag, ".flash"}, 32'(bus.goal_flash), 32'(m_phase == 3));
   endtask

   task automatic m_reset();
      m_phase = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
   endtask

   task automatic m_start(output int pulse);
      pulse = 0;
      if (m_phase == 0 || m_phase == 4) begin
         m_phase = 1; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_win = 0; pulse = 1;
      end
   endtask

   task automatic m_tick(input int x, input int y, output int pulse);
      bit mouth, l, r;
      pulse = 0;
      mouth = y >= YMIN && y <= YMAX;
      l = mouth && x <= XMIN + R;
      r = mouth && x + R >= XMAX;
      case (m_phase)
         1: begin
            m_cnt++;
            if (m_cnt == SF) begin m_phase = 2; m_cnt = 0; end
         end
         2: if (l || r) begin
            if (l) m_s2 = m_s2 < 15 ? m_s2 + 1 : 15;
            else m_s1 = m_s1 < 15 ? m_s1 + 1 : 15;
            if ((l ? m_s2 : m_s1) == WIN) begin
               m_win = l ? 2 : 1; m_phase = 4;
            end else m_phase = 3;
            m_cnt = 0;
         end
         3: begin
            m_cnt++;
            if (m_cnt == GF) begin m_phase = 1; m_cnt = 0; pulse = 1; end
         end
         default: ;
      endcase
   endtask

   task automatic frame(input int x, input int y);
      int rp, er;
      bus.ball_xpos = 12'(x);
      bus.ball_ypos = 12'(y);
      @(posedge clk); #1 vsync = 1'b1;
      @(posedge clk); #1 vsync = 1'b0;
      rp = 0;
      repeat (3) begin @(posedge clk); #1 rp += int'(bus.ball_reset); end
      m_tick(x, y, er);
      chk_all("frame");
      chk("frame.ball_reset_cycles", 32'(rp), 32'(er));
   endtask

   task automatic press();
      int rp, er, pre;
      pre = m_phase;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("start.latency_early", 32'(bus.phase), 32'(pre));
      m_start(er);
      @(posedge clk); #1 rp = int'(bus.ball_reset);
      chk("start.latency", 32'(bus.phase), 32'(m_phase));
      repeat (2) begin @(posedge clk); #1 rp += int'(bus.ball_reset); end
      chk("start.ball_reset_cycles", 32'(rp), 32'(er));
      chk_all("start");
   endtask

   task automatic to_play();
      int n = 0;
      while (m_phase != 2 && n < 400) begin frame(512, 384); n++; end
      if (m_phase != 2) begin
         checks++; errors++;
         $error("FAIL to_play: phase %0d after %0d frames, required 2", m_phase, n);
      end
   endtask

   task automatic pick(output int x, output int y);
      case ($urandom_range(0, 3))
         0: begin x = $urandom_range(0, XMIN + R); y = $urandom_range(YMIN, YMAX); end
         1: begin x = $urandom_range(XMAX - R, 4095); y = $urandom_range(YMIN, YMAX); end
         2: begin x = $urandom_range(0, 1) ? $urandom_range(0, 12) : $urandom_range(1011, 4095);
                  y = $urandom_range(0, 1) ? $urandom_range(0, YMIN - 1) : $urandom_range(YMAX + 1, 4095); end
         default: begin x = $urandom_range(0, 4095); y = $urandom_range(0, 4095); end
      endcase
   endtask

   initial begin
      int x, y, n;
      m_reset();
      bus.ball_xpos = 12'd512;
      bus.ball_ypos = 12'd384;
      vsync = 1'b1;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_all("reset");
      chk("reset.ball_reset", 32'(bus.ball_reset), 0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk_all("release_high");
      vsync = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      press();
      repeat (SF - 1) frame(512, 384);
      chk("serve.before_last", 32'(bus.phase), 1);
      frame(512, 384);
      chk("serve.play", 32'(bus.phase), 2);
      frame(10, 300);
      chk("left_goal.p2", 32'(bus.score_p2), 1);
      repeat (GF) frame(512, 384);
      chk("goal.serve", 32'(bus.phase), 1);
      to_play();
      press();
      frame(1013, 500);
      frame(1013, 484);
      chk("right_goal.p1", 32'(bus.score_p1), 1);
      to_play();
      bus.ball_xpos = 12'd0;
      bus.ball_ypos = 12'd400;
      repeat (1000) @(posedge clk);
      #1 chk_all("no_tick");
      frame(0, 400);
      chk("tick_goal.p2", 32'(bus.score_p2), 2);
      frame(0, 400);
      to_play();
      frame(1020, 300);
      to_play();
      frame(1023, 284);
      to_play();
      chk("pre_reset.p1", 32'(bus.score_p1), 3);
      @(posedge clk); #1 rst = 1'b1;
      m_reset();
      @(posedge clk); #1 chk_all("mid_reset");
      chk("mid_reset.ball_reset", 32'(bus.ball_reset), 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      press();
      n = 0;
      while (m_phase != 4 && n < 20) begin to_play(); frame(1013, 384); n++; end
      chk("p1_win.score", 32'(bus.score_p1), 7);
      chk("p1_win.winner", 32'(bus.winner), 1);
      repeat (3) frame(1013, 384);
      repeat (2) frame(5, 300);
      press();
      n = 0;
      while (m_phase != 4 && n < 3000) begin
         if (m_phase == 2) pick(x, y);
         else begin x = $urandom_range(0, 4095); y = $urandom_range(0, 4095); end
         frame(x, y);
         n++;
      end
      if (m_phase != 4) begin
         checks++; errors++;
         $error("FAIL random_match: phase %0d after %0d frames, required 4", m_phase, n);
      end
      press();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
